// File: rtl/paddsub_accum_if.sv
// ---------------------------------------------------------------------------
// paddsub_accum_if
//   Run-control and data handshake bundle for the PADDSUB nibble accumulator.
//
//   Signals (master drives the run, slave is the accumulator):
//     start     run request, sampled by the accumulator only while idle
//     len       number of words in the run, captured with start
//     init      initial accumulator value, captured with start
//     in_valid  in_data carries a word
//     in_data   16-bit word to fold into the accumulator
//     in_ready  accumulator takes a word this cycle
//     busy      run in progress
//     done      one-cycle pulse, result/sat_flags are final
//     result    accumulator register
//     sat_flags sticky per-lane saturation flags (bit i = lane i)
// ---------------------------------------------------------------------------
interface paddsub_accum_if #(
    parameter int LEN_W = 4
) ();
    logic             start;
    logic [LEN_W-1:0] len;
    logic [15:0]      init;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    logic [3:0]       sat_flags;

    modport master (
        output start,
        output len,
        output init,
        output in_valid,
        output in_data,
        input  in_ready,
        input  busy,
        input  done,
        input  result,
        input  sat_flags
    );

    modport slave (
        input  start,
        input  len,
        input  init,
        input  in_valid,
        input  in_data,
        output in_ready,
        output busy,
        output done,
        output result,
        output sat_flags
    );
endinterface

// File: rtl/paddsub_accum.sv
// ---------------------------------------------------------------------------
// paddsub_accum
//   Multi-beat saturating nibble accumulator. Loads a 16-bit initial value,
//   then folds len words into it with a lane-wise (4 x 4-bit) saturating
//   two's-complement add, recording sticky per-lane saturation events.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    paddsub_accum_if.slave (start/len/init, in_valid/in_data,
//            in_ready, busy, done, result, sat_flags)
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; result/sat_flags hold the last run
//   ACC   | accepting words, one per in_valid cycle, until cnt hits 1
//   DONE  | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module paddsub_accum #(
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    paddsub_accum_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sat_q, sat_d;

    logic [15:0]      sum_w;
    logic [3:0]       ovf_w;

    // Lane adder: four independent 4-bit saturating adds, no carry between
    // lanes. Overflow is only possible when both operands share a sign and
    // the raw sum's sign differs from it.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [3:0] a_w, b_w, raw_w;
        logic       pos_ovf_w, neg_ovf_w;

        assign a_w       = acc_q[4*g +: 4];
        assign b_w       = bus.in_data[4*g +: 4];
        assign raw_w     = a_w + b_w;
        assign pos_ovf_w = ~a_w[3] & ~b_w[3] &  raw_w[3];
        assign neg_ovf_w =  a_w[3] &  b_w[3] & ~raw_w[3];

        assign sum_w[4*g +: 4] = pos_ovf_w ? 4'h7 :
                                 neg_ovf_w ? 4'h8 : raw_w;
        assign ovf_w[g]        = pos_ovf_w | neg_ovf_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.init;
                    cnt_d   = bus.len;
                    sat_d   = '0;
                    state_d = (bus.len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                // in_ready is constant 1 here, so a beat is just in_valid.
                if (bus.in_valid) begin
                    acc_d = sum_w;
                    sat_d = sat_q | ovf_w;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs, decoded from the state register only.
    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.busy      = (state_q == ST_ACC) || (state_q == ST_DONE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.result    = acc_q;
    assign bus.sat_flags = sat_q;

endmodule

// File: doc/paddsub_accum.md
# paddsub_accum

Multi-beat saturating nibble accumulator for the PADDSUB datapath. It loads a 16-bit initial value, then folds a stream of 16-bit words into it, `len` words in total. Each fold is a lane-wise (4 × 4-bit) saturating two's-complement add, and the block records per-lane saturation events. It sits directly around the PADDSUB lane adder: it feeds the accumulator and each incoming word as the two operands, and registers the saturated sum as the next accumulator value.

## Interface
- `LEN_W`, default 4: width of the beat-count input. Maximum run length is 2^LEN_W − 1 words.
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: run request. Sampled only in IDLE.
- `len`, input, LEN_W: number of words to accumulate. Sampled together with `start`.
- `init`, input, 16: initial accumulator value. Sampled together with `start`.
- `in_valid`, input, 1: `in_data` is valid.
- `in_data`, input, 16: word to accumulate.
- `in_ready`, output, 1: block accepts a word this cycle.
- `busy`, output, 1: a run is in progress (ACC or DONE).
- `done`, output, 1: one-cycle pulse; `result` and `sat_flags` are final.
- `result`, output, 16: the accumulator register.
- `sat_flags`, output, 4: sticky per-lane saturation flags. Bit i corresponds to lane i.

## Operation
- Lane i is bits [4i+3:4i]. The four lanes are independent, with no carry between lanes.
- Lane add: compute the raw 4-bit sum r = a + b (mod 16).
  - If a and b are both non-negative and r is negative, the lane result is 0x7.
  - If a and b are both negative and r is non-negative, the lane result is 0x8.
  - Otherwise the lane result is r.
  - Either saturation case sets `sat_flags[i]`.
- State machine: IDLE, ACC, DONE.
- IDLE
  - `in_ready`=0, `busy`=0.
  - On `start`=1: acc←`init`, cnt←`len`, sat←0.
  - If `len`==0, next state is DONE; otherwise next state is ACC.
- ACC
  - `in_ready`=1, `busy`=1.
  - A beat occurs when `in_valid`&`in_ready` is high at a rising edge. On a beat: acc←lane_add(acc, `in_data`), sat←sat | lane overflow bits, cnt←cnt−1.
  - On the beat with cnt==1, next state is DONE.
  - Cycles with `in_valid`=0 change nothing.
- DONE
  - `done`=1 and `busy`=1 for exactly one cycle, `in_ready`=0.
  - Next state is IDLE unconditionally.
- `start` is ignored in ACC and DONE. `len`/`init` changes outside the IDLE start cycle have no effect.
- `result` and `sat_flags` hold their final values after DONE until the next accepted `start`. A new start overwrites them on the start edge.
- The counter is LEN_W bits. It never wraps: it is loaded with a value ≥1 on entry to ACC and leaves ACC at 1.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State goes to IDLE.
  - acc, cnt and sat go to 0.
  - Outputs: `result`=0x0000, `sat_flags`=0, `done`=0, `busy`=0, `in_ready`=0.
  - Reset asserted mid-run aborts the run immediately. No `done` is produced.
- `in_ready`, `busy` and `done` are Moore outputs decoded from the state register. There is no combinational path from `in_valid` to `in_ready`.
- Start with `len`=N≥1 accepted at edge t0:
  - ACC from t0. The earliest beat is at edge t0+1.
  - With no gaps, the last beat is at edge t0+N, and `done` is high in cycle t0+N to t0+N+1.
  - Total: N+1 cycles from start to the done pulse, plus one stall cycle per idle `in_valid` cycle.
- Start with `len`=0 at t0: `done` is high in the next cycle, with `result`=`init` and `sat_flags`=0.
- Earliest back-to-back start: the edge at which DONE→IDLE has completed, i.e. one cycle after `done`.

## Test plan
- Reset:
  - Hold `rst_n`=0 with random inputs → all outputs are 0.
  - Release `rst_n`, keep `start`=0 → `in_ready`=0 and `busy`=0 indefinitely.
- Basic run:
  - `init`=0x0000, `len`=3, words 0x1111, 0x2222, 0x1234, no gaps.
  - → `result`=0x4567, `sat_flags`=0000. `done` is high exactly one cycle, the cycle after the third beat.
- Saturation:
  - `init`=0x7878, `len`=1, word 0x1818 → `result`=0x7878, `sat_flags`=1111.
  - Then `init`=0x7000, `len`=2, words 0x1000, 0xF000 → `result`=0x6000, `sat_flags`=1000 (sticky through the non-saturating second beat).
- Flow control:
  - `init`=0x0000, `len`=4, words 0x0001, with `in_valid` low for 1–3 cycles between beats and `start` pulsed mid-run.
  - → `result`=0x0004. Exactly four beats are accepted. The mid-run `start` has no effect. `done` follows the 4th beat by one cycle.
- Zero length:
  - `init`=0xABCD, `len`=0 → `done` in the next cycle, `result`=0xABCD, `sat_flags`=0, `in_ready` never high.
- Reset mid-run:
  - `len`=5. After 2 beats, pulse `rst_n` low asynchronously (between edges).
  - → `result` goes to 0x0000 and `busy` goes to 0 without waiting for an edge. No `done` is produced. After release the block is in IDLE and a new run completes normally.
